// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDRESS_SIZE = 16;
    localparam int unsigned DMEM_DATA_SIZE    = 16;
    localparam int unsigned DMEM_SIZE         = 256;
    localparam int unsigned DMEM_PORTS        = 2;

    typedef enum logic {
        DMEM_PORT_CORE = 1'b0,
        DMEM_PORT_DMA  = 1'b1
    } dmem_port_e;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_RESP = 1'b1
    } rsp_state_e;

    // Context captured at acceptance and replayed in the response cycle.
    typedef struct packed {
        dmem_port_e port;
        logic       is_read;
        logic       err;
    } rsp_info_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-requester round-robin arbiter; the port not granted last wins contention.
module rr_arbiter_2
    import dmem_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DMEM_PORTS-1:0] req,
    output logic [DMEM_PORTS-1:0] grant,
    output logic                  transfer,
    output dmem_port_e            grant_port
);

    dmem_port_e last_grant;

    always_comb begin
        grant = '0;
        if (reset) begin
            if (req[DMEM_PORT_CORE] && req[DMEM_PORT_DMA]) begin
                if (last_grant == DMEM_PORT_DMA) grant[DMEM_PORT_CORE] = 1'b1;
                else                             grant[DMEM_PORT_DMA]  = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    assign transfer   = |grant;
    assign grant_port = grant[DMEM_PORT_DMA] ? DMEM_PORT_DMA : DMEM_PORT_CORE;

    // Reset to DMA so the core wins the first contention.
    always_ff @(posedge clock) begin
        if (!reset)        last_grant <= DMEM_PORT_DMA;
        else if (transfer) last_grant <= grant_port;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and DMA access to the single-port data memory with one-cycle responses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = DMEM_ADDRESS_SIZE,
    parameter int unsigned DATA_SIZE    = DMEM_DATA_SIZE,
    parameter int unsigned SIZE         = DMEM_SIZE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    core_req_valid,
    input  logic                    core_req_write,
    input  logic [ADDRESS_SIZE-1:0] core_req_address,
    input  logic [DATA_SIZE-1:0]    core_req_wdata,
    output logic                    core_req_ready,
    output logic                    core_rsp_valid,
    output logic [DATA_SIZE-1:0]    core_rsp_rdata,
    output logic                    core_rsp_error,
    input  logic                    dma_req_valid,
    input  logic                    dma_req_write,
    input  logic [ADDRESS_SIZE-1:0] dma_req_address,
    input  logic [DATA_SIZE-1:0]    dma_req_wdata,
    output logic                    dma_req_ready,
    output logic                    dma_rsp_valid,
    output logic [DATA_SIZE-1:0]    dma_rsp_rdata,
    output logic                    dma_rsp_error,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [DATA_SIZE-1:0]    mem_data_in,
    input  logic [DATA_SIZE-1:0]    mem_data_out
);

    // One extra bit so SIZE == 2**ADDRESS_SIZE is representable.
    localparam logic [ADDRESS_SIZE:0] SIZE_LIMIT = (ADDRESS_SIZE+1)'(SIZE);

    logic [DMEM_PORTS-1:0]   grant;
    logic                    transfer;
    dmem_port_e              grant_port;
    logic                    sel_write;
    logic [ADDRESS_SIZE-1:0] sel_address;
    logic [DATA_SIZE-1:0]    sel_wdata;
    logic                    access_error;
    logic [DATA_SIZE-1:0]    rsp_data;
    rsp_state_e              state, next_state;
    rsp_info_t               rsp_info, next_info;

    rr_arbiter_2 u_arb (
        .clock      (clock),
        .reset      (reset),
        .req        ({dma_req_valid, core_req_valid}),
        .grant      (grant),
        .transfer   (transfer),
        .grant_port (grant_port)
    );

    assign core_req_ready = grant[DMEM_PORT_CORE];
    assign dma_req_ready  = grant[DMEM_PORT_DMA];

    // Request mux; idle cycles park the memory bus at zero to limit toggling.
    always_comb begin
        sel_write   = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        if (transfer) begin
            if (grant_port == DMEM_PORT_DMA) begin
                sel_write   = dma_req_write;
                sel_address = dma_req_address;
                sel_wdata   = dma_req_wdata;
            end else begin
                sel_write   = core_req_write;
                sel_address = core_req_address;
                sel_wdata   = core_req_wdata;
            end
        end
    end

    assign access_error = transfer && ({1'b0, sel_address} >= SIZE_LIMIT);
    assign mem_address  = sel_address;
    assign mem_data_in  = sel_wdata;
    assign mem_write    = transfer &&  sel_write && !access_error;
    assign mem_read     = transfer && !sel_write && !access_error;

    assign rsp_data = (rsp_info.is_read && !rsp_info.err) ? mem_data_out : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RSP_IDLE;
            rsp_info <= '0;
        end else begin
            state    <= next_state;
            rsp_info <= next_info;
        end
    end

    // Response is also gated by reset so a pending one is dropped, not emitted.
    always_comb begin
        next_state     = RSP_IDLE;
        next_info      = rsp_info;
        core_rsp_valid = 1'b0;
        core_rsp_error = 1'b0;
        core_rsp_rdata = '0;
        dma_rsp_valid  = 1'b0;
        dma_rsp_error  = 1'b0;
        dma_rsp_rdata  = '0;
        if (transfer) begin
            next_state        = RSP_RESP;
            next_info.port    = grant_port;
            next_info.is_read = !sel_write;
            next_info.err     = access_error;
        end
        case (state)
            RSP_RESP: begin
                if (reset) begin
                    if (rsp_info.port == DMEM_PORT_DMA) begin
                        dma_rsp_valid  = 1'b1;
                        dma_rsp_error  = rsp_info.err;
                        dma_rsp_rdata  = rsp_data;
                    end else begin
                        core_rsp_valid = 1'b1;
                        core_rsp_error = rsp_info.err;
                        core_rsp_rdata = rsp_data;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
